// File: rtl/dc_step_sequencer.sv
// Steps a signed DC output through a programmable (level, dwell) table on trigger,
// with looping, slew limiting, abort, retrigger and hold-last/return-to-idle endings.
module dc_step_sequencer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 32,
  parameter int LOOP_W  = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              tbl_we,
  input  logic [AW-1:0]     tbl_addr,
  input  logic [DATA_W-1:0] tbl_level,
  input  logic [DWELL_W-1:0] tbl_dwell,
  input  logic [AW:0]       num_steps,
  input  logic [LOOP_W-1:0] loop_count,
  input  logic [DATA_W-2:0] slew,
  input  logic [DATA_W-1:0] idle_level,
  input  logic              hold_last,
  input  logic              retrig_en,
  input  logic              trig,
  input  logic              abort,
  output logic [DATA_W-1:0] dc_out,
  output logic [AW-1:0]     step_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0]  level_tbl [DEPTH];
  logic [DWELL_W-1:0] dwell_tbl [DEPTH];

  state_t             state;
  logic               trig_q;
  logic [DATA_W-1:0]  target;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [LOOP_W-1:0]  loop_cnt;

  logic               trig_rise;
  logic               can_start;
  logic [AW:0]        eff_steps;
  logic               at_last;
  logic [LOOP_W-1:0]  loop_next;
  logic               more_loops;
  logic               load;
  logic               restart;
  logic               wrap;
  logic               finish;
  logic [AW-1:0]      load_idx;
  logic [DWELL_W-1:0] load_dwell;
  logic [DATA_W-1:0]  target_n;
  logic [DATA_W-1:0]  dc_n;
  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] slew_ext;

  // Table has no reset: contents are only meaningful once written.
  always_ff @(posedge Clk) begin
    if (tbl_we && ({1'b0, tbl_addr} < DEPTH_C)) begin
      level_tbl[tbl_addr] <= tbl_level;
      dwell_tbl[tbl_addr] <= tbl_dwell;
    end
  end

  assign trig_rise  = trig & ~trig_q;
  assign eff_steps  = (num_steps > DEPTH_C) ? DEPTH_C : num_steps;
  assign can_start  = trig_rise && (eff_steps != '0);
  // >= rather than == so a mid-run shrink of num_steps ends at the current step.
  assign at_last    = ({1'b0, step_idx} + (AW+1)'(1)) >= eff_steps;
  assign loop_next  = loop_cnt + LOOP_W'(1);
  assign more_loops = (loop_count == '0) || (loop_next < loop_count);

  always_comb begin
    load     = 1'b0;
    restart  = 1'b0;
    wrap     = 1'b0;
    finish   = 1'b0;
    load_idx = '0;
    if (!abort) begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (can_start) begin
            load    = 1'b1;
            restart = 1'b1;
          end
        end
        S_RUN: begin
          if (can_start && retrig_en) begin
            load    = 1'b1;
            restart = 1'b1;
          end else if (dwell_cnt == '0) begin
            if (!at_last) begin
              load     = 1'b1;
              load_idx = step_idx + AW'(1);
            end else if (more_loops) begin
              load = 1'b1;
              wrap = 1'b1;
            end else begin
              finish = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign load_dwell = (dwell_tbl[load_idx] == '0) ? '0 : dwell_tbl[load_idx] - DWELL_W'(1);

  always_comb begin
    target_n = target;
    if (abort)
      target_n = idle_level;
    else if (load)
      target_n = level_tbl[load_idx];
    else if (state == S_IDLE)
      target_n = idle_level;
  end

  // Slew step computed one bit wider so the difference of two extreme levels cannot wrap.
  assign diff     = {target_n[DATA_W-1], target_n} - {dc_out[DATA_W-1], dc_out};
  assign slew_ext = {2'b00, slew};

  always_comb begin
    dc_n = target_n;
    if (slew != '0) begin
      if (diff > slew_ext)
        dc_n = dc_out + {1'b0, slew};
      else if (diff < -slew_ext)
        dc_n = dc_out - {1'b0, slew};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      trig_q    <= 1'b0;
      target    <= '0;
      dc_out    <= '0;
      step_idx  <= '0;
      dwell_cnt <= '0;
      loop_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      trig_q <= trig;
      target <= target_n;
      dc_out <= dc_n;
      done   <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        step_idx  <= '0;
        dwell_cnt <= '0;
        loop_cnt  <= '0;
      end else if (load) begin
        state     <= S_RUN;
        busy      <= 1'b1;
        step_idx  <= load_idx;
        dwell_cnt <= load_dwell;
        if (restart)
          loop_cnt <= '0;
        else if (wrap)
          loop_cnt <= loop_next;
      end else if (finish) begin
        state <= hold_last ? S_HOLD : S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else if (state == S_RUN) begin
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dc_step_sequencer.sv
// Directed bench: stimulus queues per-edge expectations, a negedge monitor pops and compares.
module tb_dc_step_sequencer;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               tbl_we;
  logic [2:0]         tbl_addr;
  logic [15:0]        tbl_level;
  logic [31:0]        tbl_dwell;
  logic [3:0]         num_steps;
  logic [15:0]        loop_count;
  logic [14:0]        slew;
  logic [15:0]        idle_level;
  logic               hold_last;
  logic               retrig_en;
  logic               trig;
  logic               abort;
  logic signed [15:0] dc_out;
  logic [2:0]         step_idx;
  logic               busy;
  logic               done;

  dc_step_sequencer dut (
    .Clk(Clk), .Reset(Reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_level(tbl_level), .tbl_dwell(tbl_dwell), .num_steps(num_steps),
    .loop_count(loop_count), .slew(slew), .idle_level(idle_level),
    .hold_last(hold_last), .retrig_en(retrig_en), .trig(trig), .abort(abort),
    .dc_out(dc_out), .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // mask bits: [3] dc_out, [2] step_idx, [1] busy, [0] done
  typedef struct {
    logic signed [15:0] dc;
    logic [2:0]         idx;
    logic               b;
    logic               d;
    logic [3:0]         m;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  string cur    = "reset";

  localparam logic [3:0] ALL  = 4'b1111;
  localparam logic [3:0] NOIX = 4'b1011;

  int lv3[6] = '{1000, 1000, 1000, -2000, -2000, 3000};
  int ix3[6] = '{0, 0, 0, 1, 1, 2};
  int sl[20] = '{10000, 20000, 30000, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                 22767, 12767, 2767, -7233, -17233, -27233, -32768, -32768, -32768, -32768};

  // Queue the expected outputs after the coming rising edge, then advance past it.
  task automatic tick(input int dc, input int idx, input bit b, input bit d, input logic [3:0] m);
    exp_t e;
    e.dc  = 16'(dc);
    e.idx = 3'(idx);
    e.b   = b;
    e.d   = d;
    e.m   = m;
    exp_q.push_back(e);
    name_q.push_back(cur);
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input int a, input int lvl, input int dw);
    tbl_addr  = 3'(a);
    tbl_level = 16'(lvl);
    tbl_dwell = 32'(dw);
    tbl_we    = 1'b1;
    tick(0, 0, 1'b0, 1'b0, 4'b0010);
    tbl_we    = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick(0, 0, 1'b0, 1'b0, ALL);
    abort = 1'b0;
  endtask

  always @(negedge Clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.m[3]) begin
        n_chk++;
        if (dc_out !== e.dc) begin
          n_fail++;
          $display("FAIL %s dc_out got %0d want %0d", nm, dc_out, e.dc);
        end
      end
      if (e.m[2]) begin
        n_chk++;
        if (step_idx !== e.idx) begin
          n_fail++;
          $display("FAIL %s step_idx got %0d want %0d", nm, step_idx, e.idx);
        end
      end
      if (e.m[1]) begin
        n_chk++;
        if (busy !== e.b) begin
          n_fail++;
          $display("FAIL %s busy got %b want %b", nm, busy, e.b);
        end
      end
      if (e.m[0]) begin
        n_chk++;
        if (done !== e.d) begin
          n_fail++;
          $display("FAIL %s done got %b want %b", nm, done, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_level = '0; tbl_dwell = '0;
    num_steps = 4'd3; loop_count = 16'd1; slew = '0; idle_level = '0;
    hold_last = 1'b0; retrig_en = 1'b0; trig = 1'b0; abort = 1'b0;

    tick(0, 0, 1'b0, 1'b0, ALL);
    tick(0, 0, 1'b0, 1'b0, ALL);
    Reset = 1'b0;
    cur = "reset_idle";
    tick(0, 0, 1'b0, 1'b0, ALL);

    wr(0, 1000, 3); wr(1, -2000, 2); wr(2, 3000, 1);

    cur = "basic";
    trig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(lv3[i], ix3[i], 1'b1, 1'b0, ALL);
      trig = 1'b0;
    end
    tick(3000, 0, 1'b0, 1'b1, NOIX);
    tick(0, 0, 1'b0, 1'b0, NOIX);

    cur = "loop2";
    loop_count = 16'd2;
    trig = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(lv3[i % 6], ix3[i % 6], 1'b1, 1'b0, ALL);
      trig = 1'b0;
    end
    tick(3000, 0, 1'b0, 1'b1, NOIX);
    tick(0, 0, 1'b0, 1'b0, NOIX);

    cur = "loop_inf";
    loop_count = 16'd0;
    trig = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(lv3[i % 6], ix3[i % 6], 1'b1, 1'b0, ALL);
      trig = 1'b0;
    end
    cur = "abort";
    idle_level = 16'd500;
    abort = 1'b1;
    tick(500, 0, 1'b0, 1'b0, ALL);
    abort = 1'b0;
    tick(500, 0, 1'b0, 1'b0, ALL);
    idle_level = 16'd0;
    tick(0, 0, 1'b0, 1'b0, ALL);

    cur = "abort_trig";
    abort = 1'b1; trig = 1'b1;
    tick(0, 0, 1'b0, 1'b0, ALL);
    abort = 1'b0;
    tick(0, 0, 1'b0, 1'b0, ALL);
    trig = 1'b0;
    tick(0, 0, 1'b0, 1'b0, ALL);

    loop_count = 16'd1;
    wr(0, 32767, 10); wr(1, -32768, 10);
    num_steps = 4'd2; slew = 15'd10000; hold_last = 1'b1;
    cur = "slew";
    trig = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(sl[i], i / 10, 1'b1, 1'b0, ALL);
      trig = 1'b0;
    end
    cur = "hold";
    tick(-32768, 1, 1'b0, 1'b1, NOIX);
    for (int i = 0; i < 3; i++) tick(-32768, 1, 1'b0, 1'b0, NOIX);
    cur = "hold_retrig";
    slew = '0;
    trig = 1'b1;
    tick(32767, 0, 1'b1, 1'b0, ALL);
    trig = 1'b0;
    do_abort();
    hold_last = 1'b0;

    wr(0, 100, 5); wr(1, 200, 5); wr(2, 300, 5);
    num_steps = 4'd3;
    cur = "retrig_off";
    trig = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(i < 5 ? 100 : 200, i < 5 ? 0 : 1, 1'b1, 1'b0, ALL);
      trig = 1'b0;
    end
    trig = 1'b1;
    tick(200, 1, 1'b1, 1'b0, ALL);
    trig = 1'b0;
    tick(200, 1, 1'b1, 1'b0, ALL);
    tick(200, 1, 1'b1, 1'b0, ALL);
    tick(300, 2, 1'b1, 1'b0, ALL);
    do_abort();

    cur = "retrig_on";
    retrig_en = 1'b1;
    trig = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(i < 5 ? 100 : 200, i < 5 ? 0 : 1, 1'b1, 1'b0, ALL);
      trig = 1'b0;
    end
    trig = 1'b1;
    tick(100, 0, 1'b1, 1'b0, ALL);
    trig = 1'b0;
    for (int i = 0; i < 4; i++) tick(100, 0, 1'b1, 1'b0, ALL);
    tick(200, 1, 1'b1, 1'b0, ALL);
    do_abort();
    retrig_en = 1'b0;

    wr(0, 7, 0); wr(1, 8, 2);
    num_steps = 4'd2;
    cur = "dwell0";
    trig = 1'b1;
    tick(7, 0, 1'b1, 1'b0, ALL);
    trig = 1'b0;
    tick(8, 1, 1'b1, 1'b0, ALL);
    tick(8, 1, 1'b1, 1'b0, ALL);
    tick(8, 1, 1'b0, 1'b1, NOIX);
    tick(0, 0, 1'b0, 1'b0, NOIX);

    cur = "nsteps0";
    num_steps = 4'd0;
    trig = 1'b1;
    tick(0, 0, 1'b0, 1'b0, NOIX);
    trig = 1'b0;
    tick(0, 0, 1'b0, 1'b0, NOIX);

    for (int i = 0; i < 8; i++) wr(i, 10 * (i + 1), 1);
    num_steps = 4'd15;
    cur = "nsteps15";
    trig = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(10 * (i + 1), i, 1'b1, 1'b0, ALL);
      trig = 1'b0;
    end
    tick(80, 7, 1'b0, 1'b1, ALL);
    tick(0, 0, 1'b0, 1'b0, NOIX);

    wr(0, 1000, 3); wr(1, -2000, 2); wr(2, 3000, 1);
    num_steps = 4'd3;
    cur = "reset_mid";
    trig = 1'b1;
    tick(1000, 0, 1'b1, 1'b0, ALL);
    trig = 1'b0;
    tick(1000, 0, 1'b1, 1'b0, ALL);
    tick(1000, 0, 1'b1, 1'b0, ALL);
    tick(-2000, 1, 1'b1, 1'b0, ALL);
    Reset = 1'b1;
    tick(0, 0, 1'b0, 1'b0, ALL);
    Reset = 1'b0;
    tick(0, 0, 1'b0, 1'b0, ALL);

    cur = "wr_mid";
    loop_count = 16'd2;
    trig = 1'b1;
    tick(1000, 0, 1'b1, 1'b0, ALL);
    trig = 1'b0;
    tbl_addr = 3'd0; tbl_level = 16'd555; tbl_dwell = 32'd3; tbl_we = 1'b1;
    tick(1000, 0, 1'b1, 1'b0, ALL);
    tbl_we = 1'b0;
    tick(1000, 0, 1'b1, 1'b0, ALL);
    tick(-2000, 1, 1'b1, 1'b0, ALL);
    tick(-2000, 1, 1'b1, 1'b0, ALL);
    tick(3000, 2, 1'b1, 1'b0, ALL);
    tick(555, 0, 1'b1, 1'b0, ALL);
    tick(555, 0, 1'b1, 1'b0, ALL);
    tick(555, 0, 1'b1, 1'b0, ALL);
    tick(-2000, 1, 1'b1, 1'b0, ALL);
    do_abort();

    @(negedge Clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
